// File: rtl/fifo_frame_reader.sv
`timescale 1ns/1ps
// fifo_frame_reader
//
// Reads one frame of FRAME_LEN samples from an upstream FIFO (one-cycle read
// latency) and presents it downstream on a valid/ready stream with
// start/end-of-frame markers. The frame is requested with i_start. Popped
// samples land in a 2-entry skid buffer, so downstream back-pressure never
// loses or duplicates data.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_start           request one frame (only looked at while idle)
//   i_fifo_data       upstream read data, valid the cycle after a pop
//   i_fifo_empty      upstream empty flag
//   o_fifo_pop        upstream pop request
//   o_data, o_valid   sample stream to downstream
//   i_ready           downstream accept; transfer = o_valid && i_ready
//   o_sop, o_eop      first / last sample of the frame
//   o_busy            frame in progress
//   o_frame_cnt       completed frames, wraps 255 -> 0
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_busy,
    output logic [7:0]            o_frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic                    inflight_q;
    logic [1:0]              occ_q, occ_d;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0]   skid_q [2];

    logic       xfer;
    logic [2:0] committed;

    assign o_valid     = (occ_q != 2'd0);
    assign o_data      = o_valid ? skid_q[rd_ptr_q] : '0;
    assign o_sop       = o_valid && (out_cnt_q == '0);
    assign o_eop       = o_valid && (out_cnt_q == CNT_LAST);
    assign o_busy      = (state_q != IDLE);
    assign o_frame_cnt = frame_cnt_q;

    assign xfer = o_valid && i_ready;

    // Slots already spoken for: buffered samples (minus the one leaving this
    // cycle) plus the sample still in flight from last cycle's pop. Counting
    // the departing slot as free is what lets the reader sustain one sample
    // per cycle with only two entries of buffering.
    assign committed  = {1'b0, occ_q} - {2'b00, xfer} + {2'b00, inflight_q};
    assign o_fifo_pop = (state_q == RUN) && !i_fifo_empty &&
                        (pop_cnt_q < CNT_FULL) && (committed < 3'd2);

    always_comb begin
        state_d     = state_q;
        pop_cnt_d   = pop_cnt_q + CNT_W'(o_fifo_pop);
        out_cnt_d   = out_cnt_q + CNT_W'(xfer);
        frame_cnt_d = frame_cnt_q;
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = RUN;
                    pop_cnt_d = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (pop_cnt_q == CNT_FULL) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && o_eop) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pop_cnt_q   <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= o_fifo_pop;
            occ_q       <= occ_d;
            frame_cnt_q <= frame_cnt_d;
            // The FIFO answers a pop one cycle later; capture it then.
            if (inflight_q) begin
                skid_q[wr_ptr_q] <= i_fifo_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
`timescale 1ns/1ps
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int FL = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_fifo_data = 8'hEE;
    logic          i_fifo_empty;
    logic          o_fifo_pop;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_sop;
    logic          o_eop;
    logic          o_busy;
    logic [7:0]    o_frame_cnt;

    always #5 clk = ~clk;

    fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_pop   (o_fifo_pop),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_sop        (o_sop),
        .o_eop        (o_eop),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt)
    );

    // Upstream FIFO model: data appears the cycle after a pop.
    logic [DW-1:0] fifo_mem [0:4095];
    int wr_idx = 0;
    int rd_idx = 0;
    assign i_fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (o_fifo_pop && !i_fifo_empty) begin
            i_fifo_data <= fifo_mem[rd_idx];
            rd_idx      <= rd_idx + 1;
        end else begin
            i_fifo_data <= 8'hEE;
        end
    end

    // Transfer monitor.
    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            cyc;
    } xfer_t;
    xfer_t obs[$];
    int cyc = 0;
    int outstanding = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            outstanding <= 0;
        end else begin
            outstanding <= outstanding + (o_fifo_pop ? 1 : 0) - ((o_valid && i_ready) ? 1 : 0);
            if (o_valid && i_ready) begin
                obs.push_back('{o_data, o_sop, o_eop, cyc});
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int obs_rd = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int phase = 0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic push(input int v);
        fifo_mem[wr_idx] = DW'(v);
        wr_idx++;
    endtask

    // Advance to the next falling edge, run the per-cycle checks, then
    // optionally drive the next i_ready value from the 1,0,0,1 pattern.
    task automatic tick(input bit toggle);
        @(negedge clk);
        chk("outstanding_le2", 32'(outstanding <= 2), 1);
        if (o_fifo_pop) chk("pop_while_empty", 32'(i_fifo_empty), 0);
        if (prev_stall) begin
            chk("stall_valid", 32'(o_valid), 1);
            chk("stall_data", 32'(o_data), 32'(prev_data));
        end
        if (toggle) begin
            i_ready = rdy_pat[phase];
            phase   = (phase + 1) % 4;
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
    endtask

    task automatic run_until_idle(input bit toggle, input int limit);
        int n = 0;
        do begin
            tick(toggle);
            n++;
        end while (o_busy && n < limit);
        chk("frame_done", 32'(o_busy), 0);
    endtask

    task automatic check_frame(input int first, input int n);
        int avail = obs.size() - obs_rd;
        chk("xfer_count", avail, n);
        for (int i = 0; i < n && i < avail; i++) begin
            chk("data", 32'(obs[obs_rd + i].data), 32'((first + i) & 8'hFF));
            chk("sop", 32'(obs[obs_rd + i].sop), 32'((i % FL) == 0));
            chk("eop", 32'(obs[obs_rd + i].eop), 32'((i % FL) == FL - 1));
        end
        obs_rd = obs.size();
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pop", 32'(o_fifo_pop), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_sop", 32'(o_sop), 0);
        chk("rst_eop", 32'(o_eop), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_fcnt", 32'(o_frame_cnt), 0);
        rst = 1'b0;
        tick(0);

        // Basic frame, i_ready held high; checks latency and back-to-back
        for (int i = 0; i < FL; i++) push(i);
        i_start = 1'b1;
        tick(0);
        chk("a_busy", 32'(o_busy), 1);
        chk("a_valid_c1", 32'(o_valid), 0);
        i_start = 1'b0;
        tick(0);
        chk("a_valid_c2", 32'(o_valid), 0);
        tick(0);
        chk("a_valid_c3", 32'(o_valid), 1);
        chk("a_sop_c3", 32'(o_sop), 1);
        chk("a_data_c3", 32'(o_data), 0);
        base = obs_rd;
        run_until_idle(0, 60);
        if (obs.size() >= base + FL) chk("a_b2b_span", obs[base + FL - 1].cyc - obs[base].cyc, FL - 1);
        check_frame(0, FL);
        chk("a_fcnt", 32'(o_frame_cnt), 1);

        // Back-pressure 1,0,0,1
        for (int i = 0; i < FL; i++) push(i);
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        run_until_idle(1, 120);
        i_ready = 1'b1;
        prev_stall = 1'b0;
        check_frame(0, FL);
        chk("b_fcnt", 32'(o_frame_cnt), 2);

        // FIFO runs dry after 5 samples, refilled 10 cycles later
        for (int i = 0; i < 5; i++) push(i);
        i_start = 1'b1;
        tick(0);
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(0);
            chk("c_busy", 32'(o_busy), 1);
        end
        chk("c_partial", obs.size() - obs_rd, 5);
        for (int i = 5; i < FL; i++) push(i);
        run_until_idle(0, 60);
        check_frame(0, FL);
        chk("c_fcnt", 32'(o_frame_cnt), 3);

        // i_start held across two frames
        for (int i = 0; i < 2 * FL; i++) push(i);
        base = obs_rd;
        i_start = 1'b1;
        n = 0;
        do begin
            tick(0);
            n++;
        end while (o_frame_cnt != 8'd5 && n < 200);
        i_start = 1'b0;
        chk("d_fcnt", 32'(o_frame_cnt), 5);
        tick(0);
        chk("d_idle", 32'(o_busy), 0);
        if (obs.size() >= base + 2 * FL) chk("d_gap", obs[base + FL].cyc - obs[base + FL - 1].cyc, 4);
        check_frame(0, 2 * FL);
        repeat (3) tick(0);
        chk("d_no_queue", 32'(o_busy), 0);
        chk("d_fcnt_hold", 32'(o_frame_cnt), 5);

        // Asynchronous reset after the 6th transfer
        for (int i = 0; i < FL; i++) push(i);
        i_start = 1'b1;
        tick(0);
        i_start = 1'b0;
        n = 0;
        while (obs.size() - obs_rd < 6 && n < 100) begin
            tick(0);
            n++;
        end
        chk("e_six", obs.size() - obs_rd, 6);
        rst = 1'b1;
        #1;
        chk("e_rst_valid", 32'(o_valid), 0);
        chk("e_rst_busy", 32'(o_busy), 0);
        chk("e_rst_pop", 32'(o_fifo_pop), 0);
        chk("e_rst_sop", 32'(o_sop), 0);
        chk("e_rst_eop", 32'(o_eop), 0);
        chk("e_rst_data", 32'(o_data), 0);
        chk("e_rst_fcnt", 32'(o_frame_cnt), 0);
        obs_rd = obs.size();
        prev_stall = 1'b0;
        tick(0);
        tick(0);
        rst = 1'b0;
        tick(0);
        chk("e_no_pop", 32'(o_fifo_pop), 0);
        chk("e_idle", 32'(o_busy), 0);
        for (int i = FL; i < FL + 8; i++) push(i);
        i_start = 1'b1;
        tick(0);
        i_start = 1'b0;
        run_until_idle(0, 60);
        // Samples 0..7 were popped before reset and are gone.
        check_frame(8, FL);
        chk("e_fcnt", 32'(o_frame_cnt), 1);

        // Frame counter wrap
        for (int f = 0; f < 255; f++) begin
            for (int i = 0; i < FL; i++) push(i);
            i_start = 1'b1;
            tick(0);
            i_start = 1'b0;
            run_until_idle(0, 60);
            chk("f_count", obs.size() - obs_rd, FL);
            obs_rd = obs.size();
            if (f == 253) chk("f_fcnt255", 32'(o_frame_cnt), 255);
        end
        chk("f_wrap", 32'(o_frame_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
